// File: rtl/vga_pkg.sv
// Shared types and screen constants for the VGA rectangle drawing engine.
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int XW       = 8;
    localparam int YW       = 7;
    localparam int CW       = 3;

    typedef logic [XW-1:0] coord_x_t;
    typedef logic [YW-1:0] coord_y_t;
    typedef logic [CW-1:0] color_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } rect_state_t;

    localparam coord_x_t X_ONE = coord_x_t'(1);
    localparam coord_y_t Y_ONE = coord_y_t'(1);

endpackage

// File: rtl/vga_rect_clip.sv
// Combinational clamp of a rectangle command to the visible screen area.
module vga_rect_clip
    import vga_pkg::*;
(
    input  coord_x_t x0,
    input  coord_y_t y0,
    input  coord_x_t w,
    input  coord_y_t h,
    output coord_x_t x_end,
    output coord_y_t y_end,
    output logic     empty
);

    logic [XW:0] x_sum_s;
    logic [YW:0] y_sum_s;

    // One extra bit on each sum so large widths clamp instead of wrapping
    always_comb begin
        x_sum_s = {1'b0, x0} + {1'b0, w};
        y_sum_s = {1'b0, y0} + {1'b0, h};
        if (x_sum_s > (XW+1)'(SCREEN_W)) begin
            x_end = coord_x_t'(SCREEN_W);
        end else begin
            x_end = x_sum_s[XW-1:0];
        end
        if (y_sum_s > (YW+1)'(SCREEN_H)) begin
            y_end = coord_y_t'(SCREEN_H);
        end else begin
            y_end = y_sum_s[YW-1:0];
        end
        empty = (w == coord_x_t'(0)) || (h == coord_y_t'(0)) ||
                (x0 >= coord_x_t'(SCREEN_W)) || (y0 >= coord_y_t'(SCREEN_H));
    end

endmodule

// File: rtl/vga_rect_filler.sv
// Rectangle fill engine: one clipped plot per clock in raster order, then a done pulse.
// Define VGA_RECT_OUTLINE_EN to add the cmd_outline port (outline-only drawing).
module vga_rect_filler
    import vga_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] cmd_x0,
    input  logic [YW-1:0] cmd_y0,
    input  logic [XW-1:0] cmd_w,
    input  logic [YW-1:0] cmd_h,
    input  logic [CW-1:0] cmd_color,
`ifdef VGA_RECT_OUTLINE_EN
    input  logic          cmd_outline,
`endif
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] color,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    rect_state_t state_r, state_s;
    coord_x_t    x_r, x_s, x0_r, x0_s, x_end_r, x_end_s;
    coord_y_t    y_r, y_s, y0_r, y0_s, y_end_r, y_end_s;
    color_t      color_r, color_s;
    logic        outline_r, outline_s, outline_in_s;
    logic        plot_r, busy_r, done_r, ready_r;
    logic        accept_s, last_col_s, last_row_s, skip_s;
    coord_x_t    clip_x_end_s;
    coord_y_t    clip_y_end_s;
    logic        clip_empty_s;

`ifdef VGA_RECT_OUTLINE_EN
    assign outline_in_s = cmd_outline;
`else
    assign outline_in_s = 1'b0;
`endif

    vga_rect_clip u_clip (
        .x0    (cmd_x0),
        .y0    (cmd_y0),
        .w     (cmd_w),
        .h     (cmd_h),
        .x_end (clip_x_end_s),
        .y_end (clip_y_end_s),
        .empty (clip_empty_s)
    );

    assign accept_s = cmd_valid && ready_r;

    // Next-state and raster-walk logic; x_r/y_r always hold the pixel being plotted
    always_comb begin
        state_s   = state_r;
        x_s       = x_r;
        y_s       = y_r;
        x0_s      = x0_r;
        y0_s      = y0_r;
        x_end_s   = x_end_r;
        y_end_s   = y_end_r;
        color_s   = color_r;
        outline_s = outline_r;
        last_col_s = (x_r == (x_end_r - X_ONE));
        last_row_s = (y_r == (y_end_r - Y_ONE));
        // Interior rows of an outline jump from the left edge straight to the right edge
        skip_s     = outline_r && (x_r == x0_r) && (y_r != y0_r) && !last_row_s;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (clip_empty_s) begin
                        state_s = DONE;
                    end else begin
                        state_s   = FILL;
                        x_s       = cmd_x0;
                        y_s       = cmd_y0;
                        x0_s      = cmd_x0;
                        y0_s      = cmd_y0;
                        x_end_s   = clip_x_end_s;
                        y_end_s   = clip_y_end_s;
                        color_s   = cmd_color;
                        outline_s = outline_in_s;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                if (last_col_s && last_row_s) begin
                    state_s = DONE;
                end else if (last_col_s) begin
                    x_s = x0_r;
                    y_s = y_r + Y_ONE;
                end else if (skip_s) begin
                    x_s = x_end_r - X_ONE;
                end else begin
                    x_s = x_r + X_ONE;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, captured command and registered outputs derived from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            x_r       <= coord_x_t'(0);
            y_r       <= coord_y_t'(0);
            x0_r      <= coord_x_t'(0);
            y0_r      <= coord_y_t'(0);
            x_end_r   <= coord_x_t'(0);
            y_end_r   <= coord_y_t'(0);
            color_r   <= color_t'(0);
            outline_r <= 1'b0;
            plot_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            x_r       <= x_s;
            y_r       <= y_s;
            x0_r      <= x0_s;
            y0_r      <= y0_s;
            x_end_r   <= x_end_s;
            y_end_r   <= y_end_s;
            color_r   <= color_s;
            outline_r <= outline_s;
            plot_r    <= (state_s == FILL);
            busy_r    <= (state_s != IDLE);
            done_r    <= (state_s == DONE);
            ready_r   <= (state_s == IDLE);
        end
    end

    assign cmd_ready = ready_r;
    assign x         = x_r;
    assign y         = y_r;
    assign color     = color_r;
    assign plot      = plot_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_vga_rect_filler.sv
// Directed self-checking bench for vga_rect_filler (solid fill, clipping, empty, back-to-back, reset).
module tb_vga_rect_filler;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_x0, cmd_w, x;
    logic [6:0] cmd_y0, cmd_h, y;
    logic [2:0] cmd_color, color;
    logic       plot, busy, done;
`ifdef VGA_RECT_OUTLINE_EN
    logic       cmd_outline;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int oob      = 0;
    int rb_viol  = 0;
    logic ready_prev = 1'b0;
    int px[$], py[$], pc[$], pt[$], dcyc[$], rcyc[$];
    int ex[$], ey[$], ec[$], et[$];
    int a1, a2;

    vga_rect_filler dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x0      (cmd_x0),
        .cmd_y0      (cmd_y0),
        .cmd_w       (cmd_w),
        .cmd_h       (cmd_h),
        .cmd_color   (cmd_color),
`ifdef VGA_RECT_OUTLINE_EN
        .cmd_outline (cmd_outline),
`endif
        .x           (x),
        .y           (y),
        .color       (color),
        .plot        (plot),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log plots, done pulses and cmd_ready rises with the cycle they appear in
    always @(negedge clk) begin
        if (plot) begin
            px.push_back(int'(x));
            py.push_back(int'(y));
            pc.push_back(int'(color));
            pt.push_back(cyc);
            if (x >= 8'd160 || y >= 7'd120) oob <= oob + 1;
        end
        if (done) dcyc.push_back(cyc);
        if (cmd_ready && busy) rb_viol <= rb_viol + 1;
        if (cmd_ready && !ready_prev) rcyc.push_back(cyc);
        ready_prev <= cmd_ready;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_log();
        px.delete(); py.delete(); pc.delete(); pt.delete();
        dcyc.delete(); rcyc.delete();
        ex.delete(); ey.delete(); ec.delete(); et.delete();
    endtask

    task automatic expect_px(input int xx, input int yy, input int c, input int t);
        ex.push_back(xx); ey.push_back(yy); ec.push_back(c); et.push_back(t);
    endtask

    task automatic expect_row(input int yy, input int xs, input int n, input int c, input int t0);
        for (int i = 0; i < n; i++) expect_px(xs + i, yy, c, t0 + i);
    endtask

    // Present a command and wait for the accepting edge; acc is the cycle of the first plot slot
    task automatic issue(input string tag, input int x0, input int y0, input int w, input int h,
                         input int c, input logic ol, output int acc);
        int k;
        cmd_x0 = 8'(x0); cmd_y0 = 7'(y0); cmd_w = 8'(w); cmd_h = 7'(h); cmd_color = 3'(c);
`ifdef VGA_RECT_OUTLINE_EN
        cmd_outline = ol;
`else
        if (ol) $display("outline request ignored in this build");
`endif
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        check_val({tag, ".accept"}, int'(cmd_ready), 1);
        if (cmd_ready) begin
            @(posedge clk); #1;
            acc = cyc;
        end else begin
            acc = -1000;
        end
    endtask

    task automatic drop();
        cmd_valid = 1'b0;
        cmd_x0 = 8'hAA; cmd_y0 = 7'h55; cmd_w = 8'hFF; cmd_h = 7'h7F; cmd_color = 3'd0;
`ifdef VGA_RECT_OUTLINE_EN
        cmd_outline = 1'b0;
`endif
    endtask

    task automatic check_plots(input string tag);
        check_val({tag, ".n"}, px.size(), ex.size());
        for (int i = 0; i < ex.size() && i < px.size(); i++) begin
            check_val($sformatf("%s.x%0d", tag, i), px[i], ex[i]);
            check_val($sformatf("%s.y%0d", tag, i), py[i], ey[i]);
            check_val($sformatf("%s.c%0d", tag, i), pc[i], ec[i]);
            check_val($sformatf("%s.t%0d", tag, i), pt[i], et[i]);
        end
    endtask

    task automatic check_done(input string tag, input int acc, input int p);
        check_val({tag, ".ndone"}, dcyc.size(), 1);
        check_val({tag, ".tdone"}, (dcyc.size() > 0) ? dcyc[0] : -1, acc + p);
        check_val({tag, ".tready"}, (rcyc.size() > 0) ? rcyc[0] : -1, acc + p + 1);
    endtask

    initial begin
        reset = 1'b1;
        drop();
        #3;
        check_val("rst.outs", int'({x, y, color, plot, busy, done, cmd_ready}), 0);
        @(negedge clk);
        reset = 1'b0;
        #1 check_val("rst.ready_pre", int'(cmd_ready), 0);
        @(posedge clk); #1;
        check_val("rst.ready_post", int'(cmd_ready), 1);

        // Basic 3x2 fill
        @(negedge clk); #1; clear_log();
        issue("t1", 10, 5, 3, 2, 5, 1'b0, a1); drop();
        repeat (10) @(negedge clk);
        #1;
        expect_row(5, 10, 3, 5, a1);
        expect_row(6, 10, 3, 5, a1 + 3);
        check_plots("t1");
        check_done("t1", a1, 6);

        // Clipping at the bottom-right corner
        clear_log();
        issue("t2", 158, 118, 5, 5, 7, 1'b0, a1); drop();
        repeat (8) @(negedge clk);
        #1;
        expect_row(118, 158, 2, 7, a1);
        expect_row(119, 158, 2, 7, a1 + 2);
        check_plots("t2");
        check_done("t2", a1, 4);

        // Empty commands: zero width, then off-screen x
        clear_log();
        issue("t3a", 50, 50, 0, 4, 1, 1'b0, a1); drop();
        repeat (4) @(negedge clk);
        #1;
        check_plots("t3a");
        check_done("t3a", a1, 0);
        check_val("t3a.xhold", int'(x), 159);
        check_val("t3a.yhold", int'(y), 119);
        check_val("t3a.chold", int'(color), 7);
        clear_log();
        issue("t3b", 200, 10, 5, 5, 2, 1'b0, a1); drop();
        repeat (4) @(negedge clk);
        #1;
        check_plots("t3b");
        check_done("t3b", a1, 0);

        // Back-to-back: second command held valid during the first fill
        clear_log();
        issue("t4a", 20, 30, 3, 2, 2, 1'b0, a1);
        issue("t4b", 40, 50, 2, 1, 3, 1'b0, a2); drop();
        check_val("t4.acc2", a2, a1 + 8);
        repeat (6) @(negedge clk);
        #1;
        expect_row(30, 20, 3, 2, a1);
        expect_row(31, 20, 3, 2, a1 + 3);
        expect_row(50, 40, 2, 3, a2);
        check_plots("t4");
        check_val("t4.ndone", dcyc.size(), 2);
        check_val("t4.tdone1", (dcyc.size() > 0) ? dcyc[0] : -1, a1 + 6);
        check_val("t4.tdone2", (dcyc.size() > 1) ? dcyc[1] : -1, a2 + 2);

        // Asynchronous reset after three plots of a 20-pixel fill
        clear_log();
        issue("t5", 0, 0, 5, 4, 1, 1'b0, a1); drop();
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("t5.plot", int'(plot), 0);
        check_val("t5.busy", int'(busy), 0);
        check_val("t5.ready_in_rst", int'(cmd_ready), 0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_val("t5.ready_pre", int'(cmd_ready), 0);
        @(posedge clk); #1;
        check_val("t5.ready_post", int'(cmd_ready), 1);
        repeat (5) @(negedge clk);
        #1;
        check_val("t5.nplots", px.size(), 3);
        check_val("t5.ndone", dcyc.size(), 0);

        // Single pixel at the last on-screen position
        clear_log();
        issue("t6", 159, 119, 1, 1, 6, 1'b0, a1); drop();
        repeat (5) @(negedge clk);
        #1;
        expect_px(159, 119, 6, a1);
        check_plots("t6");
        check_done("t6", a1, 1);

`ifdef VGA_RECT_OUTLINE_EN
        // Outline 4x3: interior row plots only the edge columns
        clear_log();
        issue("t7", 0, 0, 4, 3, 4, 1'b1, a1); drop();
        repeat (14) @(negedge clk);
        #1;
        expect_row(0, 0, 4, 4, a1);
        expect_px(0, 1, 4, a1 + 4);
        expect_px(3, 1, 4, a1 + 5);
        expect_row(2, 0, 4, 4, a1 + 6);
        check_plots("t7");
        check_done("t7", a1, 10);
`endif

        check_val("oob_plots", oob, 0);
        check_val("ready_while_busy", rb_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
